// File: rtl/cfg_counter_pkg.sv
// cfg_counter shared definitions.
// Mode encodings used by the counter and its bench.
package cfg_counter_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

endpackage

// File: rtl/cnt_prescaler.sv
// Prescaler for cfg_counter.
// Emits one tick every prescale+1 enabled cycles.
module cnt_prescaler
  import cfg_counter_pkg::*;
#(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] r_pre;
  logic             w_hit;

  assign w_hit = (r_pre == prescale);
  assign tick  = en & ~clr & w_hit;

  // Enabled-cycle counter; restarts on clear or terminal match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if (clr) begin
      r_pre <= '0;
    end else if (en) begin
      if (w_hit) r_pre <= '0;
      else       r_pre <= r_pre + 1'b1;
    end
  end

endmodule

// File: rtl/cfg_counter.sv
// Multi-mode configurable counter.
// Up/down/ping-pong with wrap or saturate and prescaler.
module cfg_counter
  import cfg_counter_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               PRE_W     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  input  logic             sat,
  input  logic [WIDTH-1:0] limit,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] cmpt,
  output logic             dir,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_cmpt;
  logic             r_dir;
  logic             r_tc;

  logic             w_pre_en;
  logic             w_pre_clr;
  logic             w_step;
  logic [WIDTH-1:0] w_nxt_cmpt;
  logic             w_nxt_dir;
  logic             w_nxt_tc;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;

  assign w_pre_en  = en & (mode != MODE_HOLD);
  assign w_pre_clr = clr | load;
  assign w_inc     = r_cmpt + ONE;
  assign w_dec     = r_cmpt - ONE;

  cnt_prescaler #(
    .PRE_W(PRE_W)
  ) u_pre (
    .clk     (clk),
    .rst     (rst),
    .en      (w_pre_en),
    .clr     (w_pre_clr),
    .prescale(prescale),
    .tick    (w_step)
  );

  // Next count, direction and terminal flag for one step.
  always_comb begin
    w_nxt_cmpt = r_cmpt;
    w_nxt_dir  = r_dir;
    w_nxt_tc   = 1'b0;
    case (mode)
      MODE_UP: begin
        w_nxt_dir = 1'b1;
        if (r_cmpt < limit) begin
          w_nxt_cmpt = w_inc;
          w_nxt_tc   = sat & (w_inc == limit);
        end else if (sat) begin
          w_nxt_cmpt = limit;
          w_nxt_tc   = (r_cmpt != limit);
        end else begin
          w_nxt_cmpt = ZERO;
          w_nxt_tc   = 1'b1;
        end
      end
      MODE_DOWN: begin
        w_nxt_dir = 1'b0;
        if (r_cmpt > limit) begin
          w_nxt_cmpt = limit;
        end else if (r_cmpt != ZERO) begin
          w_nxt_cmpt = w_dec;
          w_nxt_tc   = sat & (w_dec == ZERO);
        end else if (!sat) begin
          w_nxt_cmpt = limit;
          w_nxt_tc   = 1'b1;
        end
      end
      MODE_PP: begin
        if (r_dir) begin
          if (r_cmpt < limit) begin
            w_nxt_cmpt = w_inc;
            w_nxt_tc   = (w_inc == limit);
          end else begin
            w_nxt_dir  = 1'b0;
            w_nxt_cmpt = (limit == ZERO) ? ZERO : limit - ONE;
            w_nxt_tc   = (limit == ZERO);
          end
        end else begin
          if (r_cmpt != ZERO) begin
            w_nxt_cmpt = w_dec;
            w_nxt_tc   = (w_dec == ZERO);
          end else begin
            w_nxt_dir  = 1'b1;
            w_nxt_cmpt = (limit == ZERO) ? ZERO : ONE;
            w_nxt_tc   = (limit == ZERO);
          end
        end
      end
      default: begin
        w_nxt_cmpt = r_cmpt;
        w_nxt_dir  = r_dir;
        w_nxt_tc   = 1'b0;
      end
    endcase
  end

  // Count state: clear beats load beats step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmpt <= RESET_VAL;
      r_dir  <= 1'b1;
      r_tc   <= 1'b0;
    end else if (clr) begin
      r_cmpt <= ZERO;
      r_dir  <= 1'b1;
      r_tc   <= 1'b0;
    end else if (load) begin
      r_cmpt <= load_val;
      r_tc   <= 1'b0;
    end else if (w_step) begin
      r_cmpt <= w_nxt_cmpt;
      r_dir  <= w_nxt_dir;
      r_tc   <= w_nxt_tc;
    end else begin
      r_tc   <= 1'b0;
    end
  end

  assign cmpt = r_cmpt;
  assign dir  = r_dir;
  assign tc   = r_tc;

endmodule

// File: tb/tb_cfg_counter.sv
// Bench for cfg_counter.
// Vector table driven through a scoreboard queue.
module tb_cfg_counter;
  import cfg_counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic [1:0] mode = MODE_UP;
  logic       sat = 1'b0;
  logic [7:0] limit = '0;
  logic [7:0] prescale = '0;
  logic [7:0] cmpt;
  logic       dir;
  logic       tc;

  typedef struct {
    logic       e, c, l;
    logic [7:0] lv;
    logic [1:0] m;
    logic       s;
    logic [7:0] li, ps;
    logic [7:0] ec;
    logic       ed, et;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] c;
    logic       d, t;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  cfg_counter dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .mode    (mode),
    .sat     (sat),
    .limit   (limit),
    .prescale(prescale),
    .cmpt    (cmpt),
    .dir     (dir),
    .tc      (tc)
  );

  always #5 clk = ~clk;

  task automatic add(input int e, c, l, lv, m, s, li, ps, ec, ed, et);
    vec_t v;
    v.e = 1'(e); v.c = 1'(c); v.l = 1'(l);
    v.lv = 8'(lv); v.m = 2'(m); v.s = 1'(s);
    v.li = 8'(li); v.ps = 8'(ps);
    v.ec = 8'(ec); v.ed = 1'(ed); v.et = 1'(et);
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [7:0] c,
                       input logic d, input logic t);
    total++;
    if (cmpt !== c || dir !== d || tc !== t) begin
      bad++;
      $display("FAIL %s: got cmpt=%0d dir=%b tc=%b want cmpt=%0d dir=%b tc=%b",
               nm, cmpt, dir, tc, c, d, t);
    end
  endtask

  task automatic apply(input int i);
    exp_t x;
    en = tbl[i].e; clr = tbl[i].c; load = tbl[i].l;
    load_val = tbl[i].lv; mode = tbl[i].m; sat = tbl[i].s;
    limit = tbl[i].li; prescale = tbl[i].ps;
    x.idx = i; x.c = tbl[i].ec; x.d = tbl[i].ed; x.t = tbl[i].et;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check($sformatf("vec%0d", x.idx), x.c, x.d, x.t);
  endtask

  initial begin
    int seg1;
    // up wrap, limit 5
    for (int k = 1; k <= 5; k++) add(1,0,0,0, 0,0,5,0, k,1,0);
    add(1,0,0,0, 0,0,5,0, 0,1,1);
    add(1,0,0,0, 0,0,5,0, 1,1,0);
    add(1,0,0,0, 0,0,5,0, 2,1,0);
    seg1 = tbl.size();
    // up saturate, limit 3
    add(1,0,0,0, 0,1,3,0, 1,1,0);
    add(1,0,0,0, 0,1,3,0, 2,1,0);
    add(1,0,0,0, 0,1,3,0, 3,1,1);
    add(1,0,0,0, 0,1,3,0, 3,1,0);
    add(1,0,0,0, 0,1,3,0, 3,1,0);
    // load 2, down wrap, limit 4
    add(1,0,1,2, 1,0,4,0, 2,1,0);
    add(1,0,0,0, 1,0,4,0, 1,0,0);
    add(1,0,0,0, 1,0,4,0, 0,0,0);
    add(1,0,0,0, 1,0,4,0, 4,0,1);
    add(1,0,0,0, 1,0,4,0, 3,0,0);
    // hold keeps dir low
    add(1,0,0,0, 3,0,4,0, 3,0,0);
    // clr wins over load
    add(1,1,1,7, 1,0,4,0, 0,1,0);
    // ping-pong, limit 3
    add(1,0,0,0, 2,0,3,0, 1,1,0);
    add(1,0,0,0, 2,0,3,0, 2,1,0);
    add(1,0,0,0, 2,0,3,0, 3,1,1);
    add(1,0,0,0, 2,0,3,0, 2,0,0);
    add(1,0,0,0, 2,0,3,0, 1,0,0);
    add(1,0,0,0, 2,0,3,0, 0,0,1);
    add(1,0,0,0, 2,0,3,0, 1,1,0);
    // ping-pong, limit 0
    add(1,0,0,0, 2,0,0,0, 0,0,1);
    add(1,0,0,0, 2,0,0,0, 0,1,1);
    add(1,0,0,0, 2,0,0,0, 0,0,1);
    add(1,1,0,0, 2,0,0,0, 0,1,0);
    // prescale 2, up, limit 10
    add(1,0,0,0, 0,0,10,2, 0,1,0);
    add(1,0,0,0, 0,0,10,2, 0,1,0);
    add(1,0,0,0, 0,0,10,2, 1,1,0);
    add(0,0,0,0, 0,0,10,2, 1,1,0);
    add(0,0,0,0, 0,0,10,2, 1,1,0);
    add(1,0,0,0, 0,0,10,2, 1,1,0);
    add(1,0,0,0, 0,0,10,2, 1,1,0);
    add(1,0,0,0, 0,0,10,2, 2,1,0);
    add(1,0,0,0, 0,0,10,2, 2,1,0);
    add(1,0,0,0, 3,0,10,2, 2,1,0);
    add(1,0,0,0, 3,0,10,2, 2,1,0);
    add(1,0,0,0, 3,0,10,2, 2,1,0);
    add(1,0,0,0, 0,0,10,2, 2,1,0);
    add(1,0,0,0, 0,0,10,2, 3,1,0);
    // out-of-range load, limit 4
    add(1,0,1,9, 0,0,4,0, 9,1,0);
    add(1,0,0,0, 0,0,4,0, 0,1,1);
    add(1,0,1,9, 0,1,4,0, 9,1,0);
    add(1,0,0,0, 0,1,4,0, 4,1,1);
    add(1,0,1,9, 0,0,4,0, 9,1,0);
    add(1,0,0,0, 1,0,4,0, 4,0,0);

    #12;
    check("reset", 8'd0, 1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < seg1; i++) apply(i);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", 8'd0, 1'b1, 1'b0);
    rst = 1'b0;
    for (int i = seg1; i < tbl.size(); i++) apply(i);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_drain: got %0d left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
